// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM encoding,
// default reset PC and the branch-target helper.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Word offset is sign-extended and scaled to bytes; the sum wraps at 2^32.
  function automatic logic [31:0] branch_target(input logic [31:0] pc4,
                                                input logic [15:0] offset);
    return pc4 + {{14{offset[15]}}, offset, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_pc_target.sv
// Redirect target selection: jump (pseudo-direct) takes priority over a taken
// branch (PC-relative).
module pc_target
  import fetch_unit_pkg::*;
(
  input  logic        jump,
  input  logic [31:0] redirect_pc4,
  input  logic [15:0] branch_offset,
  input  logic [25:0] jump_index,
  output logic [31:0] target
);

  // Pick the jump target when jump is set, otherwise the branch target.
  always_comb begin
    if (jump) begin
      target = {redirect_pc4[31:28], jump_index, 2'b00};
    end else begin
      target = branch_target(redirect_pc4, branch_offset);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential reads to a synchronous memory,
// holds the current instruction in a skid register while decode stalls,
// and restarts from a jump/branch target on redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        jump,
  input  logic        branch_taken,
  input  logic [31:0] redirect_pc4,
  input  logic [15:0] branch_offset,
  input  logic [25:0] jump_index,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc4
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         inflight_q, inflight_d;
  logic [31:0]  fetched_pc4_q, fetched_pc4_d;
  logic [31:0]  skid_q, skid_d;
  logic [31:0]  target_s;
  logic         redirect_s;

  assign redirect_s = jump | branch_taken;

  pc_target u_pc_target (
    .jump          (jump),
    .redirect_pc4  (redirect_pc4),
    .branch_offset (branch_offset),
    .jump_index    (jump_index),
    .target        (target_s)
  );

  // Next-state and memory/decode-side outputs for the current cycle.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_d    = inflight_q;
    fetched_pc4_d = fetched_pc4_q;
    skid_d        = skid_q;
    imem_en       = 1'b0;
    imem_addr     = pc_q;
    if_valid      = 1'b0;
    if_instr      = 32'h0000_0000;
    if_pc4        = 32'h0000_0000;

    case (state_q)
      ST_BOOT: begin
        imem_en       = 1'b1;
        imem_addr     = pc_q;
        pc_d          = pc_q + PC_STEP;
        fetched_pc4_d = pc_q + PC_STEP;
        inflight_d    = 1'b1;
        state_d       = ST_RUN;
      end
      ST_RUN, ST_HOLD: begin
        if (redirect_s) begin
          imem_en       = 1'b1;
          imem_addr     = target_s;
          pc_d          = target_s + PC_STEP;
          fetched_pc4_d = target_s + PC_STEP;
          inflight_d    = 1'b1;
          skid_d        = 32'h0000_0000;
          state_d       = ST_RUN;
        end else begin
          if (state_q == ST_HOLD) begin
            if_valid = 1'b1;
            if_instr = skid_q;
          end else begin
            if_valid = inflight_q;
            if_instr = imem_rdata;
          end
          if_pc4 = fetched_pc4_q;
          if (!stall) begin
            imem_en       = 1'b1;
            imem_addr     = pc_q;
            pc_d          = pc_q + PC_STEP;
            fetched_pc4_d = pc_q + PC_STEP;
            inflight_d    = 1'b1;
            state_d       = ST_RUN;
          end else if ((state_q == ST_RUN) && inflight_q) begin
            // Memory data is only valid this cycle, so capture it for the stall.
            skid_d  = imem_rdata;
            state_d = ST_HOLD;
          end else begin
            state_d = state_q;
          end
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase

    if (rst) begin
      imem_en   = 1'b0;
      imem_addr = 32'h0000_0000;
      if_valid  = 1'b0;
      if_instr  = 32'h0000_0000;
      if_pc4    = 32'h0000_0000;
    end else begin
      if_valid = if_valid;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      fetched_pc4_q <= 32'h0000_0000;
      skid_q        <= 32'h0000_0000;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      fetched_pc4_q <= fetched_pc4_d;
      skid_q        <= skid_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory word at address A holds A, and a
// scoreboard of expected consumed instructions is compared against decode-side output.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0000_0000;
  logic        stall;
  logic        jump;
  logic        branch_taken;
  logic [31:0] redirect_pc4;
  logic [15:0] branch_offset;
  logic [25:0] jump_index;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc4;

  int n_chk = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_en       (imem_en),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .jump          (jump),
    .branch_taken  (branch_taken),
    .redirect_pc4  (redirect_pc4),
    .branch_offset (branch_offset),
    .jump_index    (jump_index),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc4        (if_pc4)
  );

  always #5 clk = ~clk;

  // Synchronous memory; data is garbage the cycle after a non-read.
  always @(posedge clk) imem_rdata <= imem_en ? imem_addr : 32'hDEAD_BEEF;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Decode consumes an instruction whenever it is valid and not stalled.
  always @(negedge clk) begin
    if (rst === 1'b0 && if_valid === 1'b1 && stall === 1'b0) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected", if_instr, 32'hFFFF_FFFF);
      end else begin
        logic [31:0] a;
        a = exp_q.pop_front();
        check_eq("sb_instr", if_instr, a);
        check_eq("sb_pc4", if_pc4, a + 32'd4);
      end
    end
  end

  task automatic drive(input logic s, input logic j, input logic b);
    @(posedge clk);
    #1;
    stall        = s;
    jump         = j;
    branch_taken = b;
    @(negedge clk);
  endtask

  task automatic chk_fetch(input string tag, input logic en, input logic [31:0] addr);
    check_eq({tag, "_en"}, {31'd0, imem_en}, {31'd0, en});
    if (en) check_eq({tag, "_addr"}, imem_addr, addr);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    redirect_pc4 = 32'h0; branch_offset = 16'h0; jump_index = 26'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_en", {31'd0, imem_en}, 32'd0);
    check_eq("rst_valid", {31'd0, if_valid}, 32'd0);
    check_eq("rst_instr", if_instr, 32'h0);
    check_eq("rst_pc4", if_pc4, 32'h0);

    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h18, 32'h1C, 32'h20,
              32'h9000_0100, 32'h400, 32'h0, 32'h4, 32'hFFFF_FFFC, 32'h0};

    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk_fetch("boot", 1'b1, 32'h0);
    check_eq("boot_valid", {31'd0, if_valid}, 32'd0);
    drive(1'b0, 1'b0, 1'b0); chk_fetch("seq1", 1'b1, 32'h4);
    drive(1'b0, 1'b0, 1'b0); chk_fetch("seq2", 1'b1, 32'h8);

    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      chk_fetch("stall", 1'b0, 32'h0);
      check_eq("stall_valid", {31'd0, if_valid}, 32'd1);
      check_eq("stall_instr", if_instr, 32'h8);
    end
    drive(1'b0, 1'b0, 1'b0); chk_fetch("release", 1'b1, 32'hC);
    drive(1'b0, 1'b0, 1'b0); chk_fetch("seq4", 1'b1, 32'h10);
    drive(1'b0, 1'b0, 1'b0); chk_fetch("seq5", 1'b1, 32'h14);

    redirect_pc4 = 32'h0000_0020; branch_offset = 16'hFFFE;
    drive(1'b0, 1'b0, 1'b1);
    chk_fetch("branch", 1'b1, 32'h18);
    check_eq("branch_valid", {31'd0, if_valid}, 32'd0);
    drive(1'b0, 1'b0, 1'b0); chk_fetch("br_seq1", 1'b1, 32'h1C);
    drive(1'b0, 1'b0, 1'b0); chk_fetch("br_seq2", 1'b1, 32'h20);
    drive(1'b0, 1'b0, 1'b0); chk_fetch("br_seq3", 1'b1, 32'h24);

    redirect_pc4 = 32'h9000_0010; jump_index = 26'h40; branch_offset = 16'h0004;
    drive(1'b0, 1'b1, 1'b1);
    chk_fetch("jump_prio", 1'b1, 32'h9000_0100);
    check_eq("jump_valid", {31'd0, if_valid}, 32'd0);
    drive(1'b0, 1'b0, 1'b0); chk_fetch("jp_seq1", 1'b1, 32'h9000_0104);
    drive(1'b1, 1'b0, 1'b0); chk_fetch("jp_stall", 1'b0, 32'h0);

    redirect_pc4 = 32'h0000_1000; jump_index = 26'h100;
    drive(1'b1, 1'b1, 1'b0);
    chk_fetch("hold_redir", 1'b1, 32'h400);
    check_eq("hold_redir_valid", {31'd0, if_valid}, 32'd0);
    drive(1'b0, 1'b0, 1'b0); chk_fetch("hr_seq1", 1'b1, 32'h404);
    drive(1'b1, 1'b0, 1'b0); chk_fetch("hr_stall", 1'b0, 32'h0);

    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    chk_fetch("mid_rst", 1'b0, 32'h0);
    check_eq("mid_rst_valid", {31'd0, if_valid}, 32'd0);
    @(posedge clk); #1; rst = 1'b0; stall = 1'b0;
    @(negedge clk);
    chk_fetch("reboot", 1'b1, 32'h0);
    check_eq("reboot_valid", {31'd0, if_valid}, 32'd0);
    drive(1'b0, 1'b0, 1'b0); chk_fetch("rb_seq1", 1'b1, 32'h4);
    drive(1'b0, 1'b0, 1'b0); chk_fetch("rb_seq2", 1'b1, 32'h8);

    redirect_pc4 = 32'hF000_0000; jump_index = 26'h3FF_FFFF;
    drive(1'b0, 1'b1, 1'b0); chk_fetch("to_top", 1'b1, 32'hFFFF_FFFC);
    drive(1'b0, 1'b0, 1'b0);
    chk_fetch("wrap", 1'b1, 32'h0000_0000);
    check_eq("wrap_pc4", if_pc4, 32'h0000_0000);
    drive(1'b0, 1'b0, 1'b0); chk_fetch("wrap_seq", 1'b1, 32'h4);

    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    check_eq("sb_drain", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 imem_en  out  1  instruction memory read strobe.
REQ-005 imem_addr  out  32  byte address of the word being read.
REQ-006 imem_rdata  in  32  read data, valid the cycle after imem_en=1 (synchronous memory).
REQ-007 stall  in  1  decode cannot accept an instruction this cycle.
REQ-008 jump  in  1  take jump this cycle (decoder Jump qualified by valid instr).
REQ-009 branch_taken  in  1  take branch this cycle (Branch AND zero).
REQ-010 redirect_pc4  in  32  PC+4 of the redirecting instruction.
REQ-011 branch_offset  in  16  branch immediate, in words.
REQ-012 jump_index  in  26  jump instr_index field.
REQ-013 if_valid  out  1  if_instr/if_pc4 hold a valid instruction for decode.
REQ-014 if_instr  out  32  instruction word; decode takes Opcode=[31:26], Funct=[5:0].
REQ-015 if_pc4  out  32  fetch address + 4 of if_instr.

Function
REQ-016 State machine: BOOT, RUN, HOLD; register pc (next issue address), inflight_q, fetched_pc4_q, skid_q.
REQ-017 BOOT: imem_en=1, imem_addr=pc, pc<=pc+4, inflight_q<=1, fetched_pc4_q<=pc+4, ->RUN; stall ignored; if_valid=0.
REQ-018 RUN, stall=0: if_valid=inflight_q, if_instr=imem_rdata, if_pc4=fetched_pc4_q; issue imem_addr=pc, imem_en=1, pc<=pc+4, inflight_q<=1, fetched_pc4_q<=pc+4.
REQ-019 RUN, stall=1, inflight_q=1: skid_q<=imem_rdata, imem_en=0, pc unchanged, ->HOLD.
REQ-020 RUN, stall=1, inflight_q=0: imem_en=0, stay RUN, nothing changes.
REQ-021 HOLD: if_valid=1, if_instr=skid_q, if_pc4=fetched_pc4_q, imem_en=0 while stall=1; on stall=0 issue as REQ-018 and ->RUN.
REQ-022 Redirect (jump or branch_taken) in RUN or HOLD, regardless of stall: if_valid=0, imem_en=1, imem_addr=target, pc<=target+4, fetched_pc4_q<=target+4, inflight_q<=1, skid_q discarded, ->RUN.
REQ-023 Jump target = {redirect_pc4[31:28], jump_index, 2'b00}.
REQ-024 Branch target = redirect_pc4 + (sign-extended branch_offset << 2), modulo 2^32.
REQ-025 jump and branch_taken together: jump wins.
REQ-026 Redirect in BOOT: ignored (no instruction yet issued).
REQ-027 All PC arithmetic wraps at 2^32 silently; 32'hFFFF_FFFC + 4 = 0.
REQ-028 Fetch-to-if_valid latency: 1 cycle with no stall; each instruction shown exactly once with stall=0.

Reset
REQ-029 rst=1 at any clock edge, including mid-HOLD or mid-redirect: state<=BOOT, pc<=RESET_PC, inflight_q<=0, skid_q<=0, fetched_pc4_q<=0.
REQ-030 While rst=1: imem_en=0, if_valid=0, if_instr=0, if_pc4=0.
REQ-031 First imem_en=1 is the first cycle after rst deasserts, address RESET_PC.

Structure
REQ-032 FSM state encodings and default RESET_PC value in shared define.v.
REQ-033 Target computation (REQ-023..025) in one combinational sub-module pc_target; rest in fetch_unit.

Verification
REQ-034 Reset, RESET_PC=0, stall=0, memory word at A = A: imem_addr 0,4,8,...; if_instr 0,4,8 one cycle later, if_pc4 = 4,8,12.
REQ-035 stall held 3 cycles while instr@8 valid: if_instr=8 held all 3 cycles, imem_en=0, no instr skipped or duplicated after release.
REQ-036 Branch from redirect_pc4=0x20, offset=16'hFFFE: next imem_addr=0x18, if_valid=0 that cycle, then instr 0x18, 0x1C.
REQ-037 jump and branch_taken together, redirect_pc4=0x9000_0010, jump_index=0x40: imem_addr=0x9000_0100.
REQ-038 Redirect during HOLD with stall=1: skid dropped, if_valid=0, fetch from target next; rst pulsed mid-HOLD -> BOOT, refetch RESET_PC.
REQ-039 pc=0xFFFF_FFFC, no stall: next imem_addr=0x0000_0000, if_pc4=0x0000_0000 for that instruction.
